// File: rtl/sbox_hpc1_d2_driver.sv
// Issue/collect driver around the 2nd-order HPC1 clock-gated Skinny S-box.
// Optional build macro REMASK_EN refreshes the input sharing on accept.

module sbox_hpc1_d2_share_lane #(
   parameter int VEC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic             capture,
   input  logic [VEC_W-1:0] in_sh,
   input  logic [VEC_W-1:0] mask,
   input  logic [VEC_W-1:0] y_sh,
   output logic [VEC_W-1:0] x_sh,
   output logic [VEC_W-1:0] out_sh
);
   // One share only: nothing here ever sees a sibling share.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_sh   <= '0;
         out_sh <= '0;
      end else begin
         if (accept)  x_sh   <= in_sh ^ mask;
         if (capture) out_sh <= y_sh;
      end
   end
endmodule

module sbox_hpc1_d2_driver #(
   parameter int LATENCY = 5,
   parameter int TIMEOUT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [31:0] seed,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_s0,
   input  logic [3:0]  in_s1,
   input  logic [3:0]  in_s2,
   output logic [3:0]  sb_x_s0,
   output logic [3:0]  sb_x_s1,
   output logic [3:0]  sb_x_s2,
   output logic [19:0] sb_fresh,
   input  logic        sb_synch,
   input  logic [3:0]  sb_y_s0,
   input  logic [3:0]  sb_y_s1,
   input  logic [3:0]  sb_y_s2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_s0,
   output logic [3:0]  out_s1,
   output logic [3:0]  out_s2,
   output logic        err_timeout
);
   localparam int NUM_SHARES = 3;
   localparam int VEC_W      = 4;
   localparam int CNT_W      = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                               state_q, state_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic [31:0]                          prng_q, prng_d;
   logic [19:0]                          fresh_q;
   logic                                 out_valid_q, out_valid_d;
   logic                                 err_q, err_d;
   logic                                 accept, capture, synch_ok, ready_c;
   logic [NUM_SHARES-1:0][VEC_W-1:0]     in_sh, y_sh, x_sh, out_sh, mask;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   assign in_sh = {in_s2, in_s1, in_s0};
   assign y_sh  = {sb_y_s2, sb_y_s1, sb_y_s0};

`ifdef REMASK_EN
   logic [7:0] r;
   assign r    = prng_q[27:20];
   // Each nibble of r lands on exactly two shares, so the XOR is preserved.
   assign mask = {r[7:4], r[3:0], r[3:0] ^ r[7:4]};
`else
   assign mask = '0;
`endif

   always_comb begin
      prng_d = xorshift32(prng_q);
      if (state_q == IDLE && seed_load)
         prng_d = (seed == 32'h0) ? 32'h1 : seed;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      ready_c     = 1'b0;
      accept      = 1'b0;
      capture     = 1'b0;
      // Synch before a full window has elapsed closes a stale gated period.
      synch_ok    = sb_synch && (cnt_q >= CNT_W'(LATENCY - 1));
      case (state_q)
         IDLE: begin
            ready_c = ~seed_load;
            if (in_valid && !seed_load) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
            if (synch_ok) begin
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         DONE: begin
            // Y shares are valid the cycle after Synch; grab them once.
            if (!out_valid_q) begin
               capture     = 1'b1;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prng_q      <= 32'h1;
         fresh_q     <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prng_q      <= prng_d;
         fresh_q     <= prng_q[19:0];
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_SHARES; g++) begin : g_lane
      sbox_hpc1_d2_share_lane #(.VEC_W(VEC_W)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .accept  (accept),
         .capture (capture),
         .in_sh   (in_sh[g]),
         .mask    (mask[g]),
         .y_sh    (y_sh[g]),
         .x_sh    (x_sh[g]),
         .out_sh  (out_sh[g])
      );
   end

   assign in_ready    = ready_c & rst;
   assign sb_x_s0     = x_sh[0];
   assign sb_x_s1     = x_sh[1];
   assign sb_x_s2     = x_sh[2];
   assign sb_fresh    = fresh_q;
   assign out_valid   = out_valid_q;
   assign out_s0      = out_sh[0];
   assign out_s1      = out_sh[1];
   assign out_s2      = out_sh[2];
   assign err_timeout = err_q;
endmodule

// File: tb/tb_sbox_hpc1_d2_driver.sv
// Bench for sbox_hpc1_d2_driver: behavioural S-box environment plus golden
// xorshift32 and Skinny table models.
module tb_sbox_hpc1_d2_driver;
   localparam int LATENCY = 5;
   localparam int TIMEOUT = 12;

   logic        clk = 1'b0, rst = 1'b0, seed_load = 1'b0;
   logic [31:0] seed = '0;
   logic        in_valid = 1'b0, in_ready;
   logic [3:0]  in_s0 = '0, in_s1 = '0, in_s2 = '0;
   logic [3:0]  sb_x_s0, sb_x_s1, sb_x_s2;
   logic [19:0] sb_fresh;
   logic        sb_synch = 1'b0;
   logic [3:0]  sb_y_s0 = '0, sb_y_s1 = '0, sb_y_s2 = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [3:0]  out_s0, out_s1, out_s2;
   logic        err_timeout;

   int checks = 0, failures = 0;
   // S-box environment: k = cycles since accept, mode 0 periodic, 1 silent, 2 early pulse
   int k = 0, mode = 0;
   bit busy = 0;

   sbox_hpc1_d2_driver #(.LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
      .sb_x_s0(sb_x_s0), .sb_x_s1(sb_x_s1), .sb_x_s2(sb_x_s2),
      .sb_fresh(sb_fresh), .sb_synch(sb_synch),
      .sb_y_s0(sb_y_s0), .sb_y_s1(sb_y_s1), .sb_y_s2(sb_y_s2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] skinny(input logic [3:0] x);
      case (x)
         4'h0: return 4'hc;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
         4'h4: return 4'h1;  4'h5: return 4'ha;  4'h6: return 4'h2;  4'h7: return 4'hb;
         4'h8: return 4'h3;  4'h9: return 4'h8;  4'ha: return 4'h5;  4'hb: return 4'hd;
         4'hc: return 4'h4;  4'hd: return 4'he;  4'he: return 4'h7;  default: return 4'hf;
      endcase
   endfunction

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      return t ^ (t << 5);
   endfunction

   function automatic bit is_synch(input int kk);
      if (mode == 0) return (kk % LATENCY) == LATENCY - 1;
      if (mode == 2) return kk == 1 || kk == 2 * LATENCY - 1;
      return 1'b0;
   endfunction

   // One clock; environment updates at the falling edge.
   task automatic tick();
      logic acc;
      logic [3:0] a, b, y;
      #1;
      acc = in_valid && in_ready && rst;
      @(posedge clk);
      @(negedge clk);
      if (!rst) busy = 0;
      else if (acc) begin busy = 1; k = 0; end
      else if (busy) k++;
      sb_synch = busy && is_synch(k);
      if (busy && k >= LATENCY && is_synch(k - 1)) begin
         y = skinny(sb_x_s0 ^ sb_x_s1 ^ sb_x_s2);
         a = 4'($urandom); b = 4'($urandom);
         sb_y_s0 = a; sb_y_s1 = b; sb_y_s2 = y ^ a ^ b;
      end else begin
         {sb_y_s0, sb_y_s1, sb_y_s2} = 12'($urandom);
      end
   endtask

   task automatic issue(input logic [3:0] a, b, c, output bit ok);
      in_s0 = a; in_s1 = b; in_s2 = c; in_valid = 1; ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         #1;
         if (in_ready) ok = 1;
         tick();
      end
      in_valid = 0;
   endtask

   task automatic wait_out(input int max, output int n, output bit ok);
      n = 0; ok = out_valid;
      while (!ok && n < max) begin tick(); n++; ok = out_valid; end
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, err_timeout} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {in_ready, out_valid, err_timeout});
      end
      checks++;
      if ({sb_x_s0, sb_x_s1, sb_x_s2, out_s0, out_s1, out_s2, sb_fresh} !== '0) begin
         failures++; $display("FAIL reset_data got x=%h%h%h out=%h%h%h fresh=%h exp=0",
            sb_x_s0, sb_x_s1, sb_x_s2, out_s0, out_s1, out_s2, sb_fresh);
      end
      rst = 1; busy = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_seed();
      logic [31:0] g, s;
      for (int r = 0; r < 2; r++) begin
         s = (r == 0) ? 32'h0 : ($urandom | 32'h1);
         seed_load = 1; seed = s; in_valid = 1;
         #1;
         checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL seed_blocks_ready got=%b exp=0", in_ready); end
         tick();
         seed_load = 0; in_valid = 0;
         tick();
         g = (s == 0) ? 32'h1 : s;
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (sb_fresh !== g[19:0]) begin
               failures++; $display("FAIL seed_fresh[%0d] got=%h exp=%h", i, sb_fresh, g[19:0]);
            end
            g = xs32(g);
            tick();
         end
      end
   endtask

   task automatic test_single_op();
      bit ok; int n;
      mode = 0;
      issue(4'h1, 4'h2, 4'h4, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_accept got=none exp=accept"); end
`ifndef REMASK_EN
      checks++;
      if ({sb_x_s0, sb_x_s1, sb_x_s2} !== 12'h124) begin
         failures++; $display("FAIL single_x got=%h%h%h exp=124", sb_x_s0, sb_x_s1, sb_x_s2);
      end
`endif
      wait_out(LATENCY + 3, n, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_latency got=>%0d exp<=%0d", n, LATENCY + 3); end
      checks++;
      if ((out_s0 ^ out_s1 ^ out_s2) !== 4'hb) begin
         failures++; $display("FAIL single_value got=%h exp=b", out_s0 ^ out_s1 ^ out_s2);
      end
      out_ready = 1; tick(); out_ready = 0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++; $display("FAIL single_release got=%b exp=01", {out_valid, in_ready});
      end
   endtask

   task automatic test_sweep();
      bit ok; int n, stall;
      logic [3:0] a, b, c;
      logic [11:0] hold;
      mode = 0;
      for (int x = 0; x < 16; x++) begin
         a = 4'($urandom); b = 4'($urandom); c = 4'(x) ^ a ^ b;
         issue(a, b, c, ok);
         checks++;
         if (!ok || (sb_x_s0 ^ sb_x_s1 ^ sb_x_s2) !== 4'(x)) begin
            failures++; $display("FAIL sweep_x[%0d] got=%h exp=%h", x, sb_x_s0 ^ sb_x_s1 ^ sb_x_s2, 4'(x));
         end
         wait_out(LATENCY + 3, n, ok);
         checks++;
         if (!ok || (out_s0 ^ out_s1 ^ out_s2) !== skinny(4'(x))) begin
            failures++; $display("FAIL sweep_y[%0d] got=%h valid=%b exp=%h", x, out_s0 ^ out_s1 ^ out_s2, ok, skinny(4'(x)));
         end
         hold = {out_s0, out_s1, out_s2};
         stall = $urandom_range(0, 3);
         in_valid = 1; in_s0 = 4'($urandom);
         for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, out_s0, out_s1, out_s2} !== {2'b10, hold}) begin
               failures++; $display("FAIL sweep_stall[%0d] got=%b%b %h exp=10 %h", x, out_valid, in_ready, {out_s0, out_s1, out_s2}, hold);
            end
         end
         in_valid = 0;
         out_ready = 1; tick(); out_ready = 0;
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL sweep_handshake[%0d] got=%b exp=0", x, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int n;
      logic [3:0] a, b;
      mode = 0;
      issue(4'h3, 4'h0, 4'h0, ok);
      wait_out(LATENCY + 3, n, ok);
      a = 4'($urandom); b = 4'($urandom);
      in_s0 = a; in_s1 = b; in_s2 = 4'h9 ^ a ^ b; in_valid = 1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_done got=%b exp=0", in_ready); end
      out_ready = 1; tick(); out_ready = 0;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++; $display("FAIL b2b_after_handshake got=%b exp=01", {out_valid, in_ready});
      end
      issue(a, b, 4'h9 ^ a ^ b, ok);
      wait_out(LATENCY + 3, n, ok);
      checks++;
      if (!ok || (out_s0 ^ out_s1 ^ out_s2) !== skinny(4'h9)) begin
         failures++; $display("FAIL b2b_value got=%h exp=%h", out_s0 ^ out_s1 ^ out_s2, skinny(4'h9));
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_early_synch();
      bit ok, early; int n;
      logic [3:0] x;
      mode = 2;
      x = 4'($urandom);
      issue(x, 4'h5, 4'h5, ok);
      early = out_valid;
      for (int i = 1; i <= 2 * LATENCY - 1; i++) begin tick(); early |= out_valid; end
      checks++;
      if (early !== 1'b0) begin failures++; $display("FAIL early_ignored got=valid exp=no_valid"); end
      wait_out(4, n, ok);
      checks++;
      if (!ok || (out_s0 ^ out_s1 ^ out_s2) !== skinny(x)) begin
         failures++; $display("FAIL early_value got=%h valid=%b exp=%h", out_s0 ^ out_s1 ^ out_s2, ok, skinny(x));
      end
      out_ready = 1; tick(); out_ready = 0;
      mode = 0;
   endtask

   task automatic test_timeout();
      bit ok, bad; int n;
      mode = 1;
      issue(4'h6, 4'h0, 4'h0, ok);
      bad = 0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         bad |= err_timeout | in_ready | out_valid;
      end
      checks++;
      if (bad !== 1'b0) begin failures++; $display("FAIL timeout_early got=flag exp=quiet_until_%0d", TIMEOUT); end
      tick();
      checks++;
      if ({err_timeout, in_ready, out_valid} !== 3'b110) begin
         failures++; $display("FAIL timeout_abort got=%b exp=110", {err_timeout, in_ready, out_valid});
      end
      mode = 0;
      issue(4'h2, 4'h0, 4'h0, ok);
      wait_out(LATENCY + 3, n, ok);
      checks++;
      if (!ok || err_timeout !== 1'b1 || (out_s0 ^ out_s1 ^ out_s2) !== skinny(4'h2)) begin
         failures++; $display("FAIL timeout_sticky got=err%b y=%h exp=err1 y=%h", err_timeout, out_s0 ^ out_s1 ^ out_s2, skinny(4'h2));
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_reset_mid_run();
      bit ok, seen; int n;
      logic [3:0] x;
      mode = 0;
      issue(4'hd, 4'h1, 4'h1, ok);
      tick(); tick();
      rst = 0;
      #1;
      checks++;
      if ({out_valid, in_ready, err_timeout, sb_x_s0, sb_x_s1, sb_x_s2, out_s0, out_s1, out_s2} !== '0) begin
         failures++; $display("FAIL midrun_clear got=%b%b%b x=%h%h%h exp=all0", out_valid, in_ready, err_timeout, sb_x_s0, sb_x_s1, sb_x_s2);
      end
      tick();
      rst = 1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); seen |= out_valid; end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL midrun_no_result got=valid exp=no_valid"); end
      x = 4'($urandom);
      issue(x ^ 4'h3, 4'h3, 4'h0, ok);
      wait_out(LATENCY + 3, n, ok);
      checks++;
      if (!ok || (out_s0 ^ out_s1 ^ out_s2) !== skinny(x)) begin
         failures++; $display("FAIL midrun_next_op got=%h valid=%b exp=%h", out_s0 ^ out_s1 ^ out_s2, ok, skinny(x));
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

`ifdef REMASK_EN
   task automatic test_remask();
      bit ok, differ; int n;
      differ = 0;
      for (int i = 0; i < 4; i++) begin
         issue(4'h3, 4'h5, 4'hc, ok);
         checks++;
         if ((sb_x_s0 ^ sb_x_s1 ^ sb_x_s2) !== 4'ha) begin
            failures++; $display("FAIL remask_xor got=%h exp=a", sb_x_s0 ^ sb_x_s1 ^ sb_x_s2);
         end
         if ({sb_x_s0, sb_x_s1, sb_x_s2} !== 12'h35c) differ = 1;
         wait_out(LATENCY + 3, n, ok);
         out_ready = 1; tick(); out_ready = 0;
      end
      checks++;
      if (!differ) begin failures++; $display("FAIL remask_differs got=unmasked exp=refreshed"); end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_seed();
      test_single_op();
      test_sweep();
      test_back_to_back();
      test_early_synch();
      test_timeout();
      test_reset_mid_run();
`ifdef REMASK_EN
      test_remask();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
